// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the sprite pipeline.
// Phase encoding, dot boundaries and CPU register indices.
package ppu_pkg;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_CLEAR,
    PH_EVAL,
    PH_FETCH,
    PH_TAIL
  } phase_e;

  localparam logic [8:0] DOT_CLEAR_END = 9'd64;
  localparam logic [8:0] DOT_EVAL_END  = 9'd256;
  localparam logic [8:0] DOT_FETCH_END = 9'd320;

  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;

  function automatic logic [7:0] next_entry(input logic [7:0] a);
    return {a[7:2] + 6'd1, 2'b00};
  endfunction

endpackage

// File: rtl/sprite_pipeline_controller_if.sv
// sprite_pipeline_controller_if: PPU timing, CPU port and handler bundle.
// master drives timing/CPU/strobes, slave is the controller.
interface sprite_pipeline_controller_if;
  logic       clock_EN;
  logic [8:0] dot;
  logic [8:0] scanline;
  logic       showSprites;
  logic       showBackground;
  logic [2:0] regSel;
  logic       regWrite;
  logic       regRead;
  logic [7:0] cpuData_IN;
  logic       oamNextAttr;
  logic       oamNextEntry;
  logic       spriteEvalReset;
  logic       spriteEval_EN;
  logic       spriteFetch_EN;
  logic       pixelShifty_EN;
  logic       resetFlags;
  logic       cpuComm_EN;
  logic       cpuRW;
  logic [7:0] primaryAddress;

  modport master (
    output clock_EN, dot, scanline,
    output showSprites, showBackground,
    output regSel, regWrite, regRead, cpuData_IN,
    output oamNextAttr, oamNextEntry,
    input  spriteEvalReset, spriteEval_EN,
    input  spriteFetch_EN, pixelShifty_EN,
    input  resetFlags, cpuComm_EN, cpuRW,
    input  primaryAddress
  );

  modport slave (
    input  clock_EN, dot, scanline,
    input  showSprites, showBackground,
    input  regSel, regWrite, regRead, cpuData_IN,
    input  oamNextAttr, oamNextEntry,
    output spriteEvalReset, spriteEval_EN,
    output spriteFetch_EN, pixelShifty_EN,
    output resetFlags, cpuComm_EN, cpuRW,
    output primaryAddress
  );
endinterface

// File: rtl/cpu_req_latch.sv
// cpu_req_latch: one-deep pending CPU register request.
// Catches single-clock strobes until a clock_EN cycle consumes them.
module cpu_req_latch
  import ppu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       reg_write_i,
  input  logic       reg_read_i,
  input  logic [2:0] reg_sel_i,
  input  logic [7:0] data_i,
  input  logic       consume_i,
  output logic       pend_v_o,
  output logic       pend_rd_o,
  output logic [2:0] pend_sel_o,
  output logic [7:0] pend_data_o
);
  logic       v_q;
  logic       rd_q;
  logic [2:0] sel_q;
  logic [7:0] data_q;

  // A new strobe always wins over consumption of the old one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q    <= 1'b0;
      rd_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
    end else if (reg_write_i | reg_read_i) begin
      v_q    <= 1'b1;
      rd_q   <= reg_read_i;
      sel_q  <= reg_sel_i;
      data_q <= data_i;
    end else if (consume_i) begin
      v_q <= 1'b0;
    end
  end

  assign pend_v_o    = v_q;
  assign pend_rd_o   = rd_q;
  assign pend_sel_o  = sel_q;
  assign pend_data_o = data_q;
endmodule

// File: rtl/sprite_pipeline_controller.sv
// sprite_pipeline_controller: sprite phase sequencer and OAMADDR owner.
// Phase controls and address are registered one dot behind the decode.
module sprite_pipeline_controller
  import ppu_pkg::*;
#(
  parameter int LAST_VISIBLE_LINE = 239,
  parameter int PRERENDER_LINE    = 261,
  parameter int LAST_DOT          = 340
) (
  input logic clock,
  input logic reset,
  sprite_pipeline_controller_if.slave bus
);
  localparam logic [8:0] LVL  = 9'(LAST_VISIBLE_LINE);
  localparam logic [8:0] PRL  = 9'(PRERENDER_LINE);
  localparam logic [8:0] LDOT = 9'(LAST_DOT);

  logic   visible, prerender, rendering, dot0, run;
  logic   in_clear, in_eval, in_fetch, in_tail;
  phase_e state_q, phase_d;
  logic   sync_q;
  logic   evr_q, eval_q, fetch_q, shift_q, rflag_q;

  assign visible   = bus.scanline <= LVL;
  assign prerender = bus.scanline == PRL;
  assign rendering = (bus.showSprites | bus.showBackground)
                   & (visible | prerender);
  assign dot0      = bus.dot == 9'd0;
  assign run       = rendering & (sync_q | dot0);
  assign in_clear  = bus.dot >= 9'd1 && bus.dot <= DOT_CLEAR_END;
  assign in_eval   = bus.dot > DOT_CLEAR_END && bus.dot <= DOT_EVAL_END;
  assign in_fetch  = bus.dot > DOT_EVAL_END && bus.dot <= DOT_FETCH_END;
  assign in_tail   = bus.dot > DOT_FETCH_END && bus.dot <= LDOT;

  // Decode the phase the handler runs in the coming dot.
  always_comb begin
    phase_d = PH_IDLE;
    unique case (1'b1)
      run && visible && in_clear: phase_d = PH_CLEAR;
      run && visible && in_eval:  phase_d = PH_EVAL;
      run && in_fetch:            phase_d = PH_FETCH;
      run && in_tail:             phase_d = PH_TAIL;
      default:                    phase_d = PH_IDLE;
    endcase
  end

  // Phase state plus registered handler controls; reset unsyncs until dot 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PH_IDLE;
      sync_q  <= 1'b0;
      evr_q   <= 1'b0;
      eval_q  <= 1'b0;
      fetch_q <= 1'b0;
      shift_q <= 1'b0;
      rflag_q <= 1'b0;
    end else if (bus.clock_EN) begin
      state_q <= phase_d;
      if (dot0) sync_q <= 1'b1;
      evr_q   <= rendering & dot0;
      eval_q  <= (phase_d == PH_CLEAR) | (phase_d == PH_EVAL);
      fetch_q <= phase_d == PH_FETCH;
      shift_q <= run & visible & (in_clear | in_eval);
      rflag_q <= prerender & (bus.dot == 9'd1);
    end
  end

  logic       pend_v, pend_rd, consume;
  logic [2:0] pend_sel;
  logic [7:0] pend_data;

  cpu_req_latch u_req (
    .clock       (clock),
    .reset       (reset),
    .reg_write_i (bus.regWrite),
    .reg_read_i  (bus.regRead),
    .reg_sel_i   (bus.regSel),
    .data_i      (bus.cpuData_IN),
    .consume_i   (consume),
    .pend_v_o    (pend_v),
    .pend_rd_o   (pend_rd),
    .pend_sel_o  (pend_sel),
    .pend_data_o (pend_data)
  );

  logic       is_addr, is_data;
  logic [7:0] addr_q, addr_d, base;
  logic       inc_q, inc_d, defer_q, defer_d;
  logic       comm_q, comm_d, rw_q, rw_d, take_d;

  assign is_addr = pend_v & ~pend_rd & (pend_sel == REG_OAMADDR);
  assign is_data = pend_v & (pend_sel == REG_OAMDATA);

  // Address priority: $2003, fetch clear, $2004, then eval strobes.
  // A $2004 blocked by fetch waits one cycle, then goes ahead of it.
  always_comb begin
    base    = inc_q ? addr_q + 8'd1 : addr_q;
    addr_d  = base;
    inc_d   = 1'b0;
    defer_d = 1'b0;
    comm_d  = 1'b0;
    rw_d    = 1'b0;
    take_d  = pend_v & ~is_addr & ~is_data;
    if (is_addr) begin
      addr_d = pend_data;
      take_d = 1'b1;
    end else if (phase_d == PH_FETCH && !(is_data && defer_q)) begin
      addr_d  = 8'h00;
      defer_d = is_data;
    end else if (is_data && !pend_rd && rendering) begin
      addr_d = {base[7:2] + 6'd1, base[1:0]};
      take_d = 1'b1;
    end else if (is_data && !pend_rd) begin
      comm_d = 1'b1;
      inc_d  = 1'b1;
      take_d = 1'b1;
    end else if (is_data) begin
      comm_d = 1'b1;
      rw_d   = 1'b1;
      take_d = 1'b1;
    end else if (state_q == PH_EVAL && bus.oamNextEntry) begin
      addr_d = next_entry(base);
    end else if (state_q == PH_EVAL && bus.oamNextAttr) begin
      addr_d = base + 8'd1;
    end
  end

  assign consume = bus.clock_EN & take_d;

  // OAM address and CPU port registers, advanced once per dot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= 8'h00;
      inc_q   <= 1'b0;
      defer_q <= 1'b0;
      comm_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else if (bus.clock_EN) begin
      addr_q  <= addr_d;
      inc_q   <= inc_d;
      defer_q <= defer_d;
      comm_q  <= comm_d;
      rw_q    <= rw_d;
    end
  end

  assign bus.spriteEvalReset = evr_q;
  assign bus.spriteEval_EN   = eval_q;
  assign bus.spriteFetch_EN  = fetch_q;
  assign bus.pixelShifty_EN  = shift_q;
  assign bus.resetFlags      = rflag_q;
  assign bus.cpuComm_EN      = comm_q;
  assign bus.cpuRW           = rw_q;
  assign bus.primaryAddress  = addr_q;
endmodule

// File: tb/tb_sprite_pipeline_controller.sv
// tb_sprite_pipeline_controller: scoreboard bench for the sprite controller.
// Address and CPU-port expectations are queued at drive time.
module tb_sprite_pipeline_controller;
  logic clock = 1'b0;
  logic reset;

  sprite_pipeline_controller_if bus();

  sprite_pipeline_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
  } comm_t;

  comm_t      comm_q[$];
  logic [7:0] addr_q[$];

  int checks = 0;
  int failures = 0;
  int n_evr = 0, n_eval = 0, n_fetch = 0, n_shift = 0;
  int n_rflag = 0, n_fnz = 0, n_comm = 0;
  int s_evr, s_eval, s_fetch, s_shift, s_rflag, s_fnz, s_comm;
  int d = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_evr = n_evr; s_eval = n_eval; s_fetch = n_fetch;
    s_shift = n_shift; s_rflag = n_rflag; s_fnz = n_fnz;
    s_comm = n_comm;
  endtask

  task automatic tick();
    logic  en;
    comm_t e;
    en = bus.clock_EN;
    bus.dot = 9'(d);
    @(posedge clock);
    #1;
    bus.regWrite = 1'b0;
    bus.regRead = 1'b0;
    bus.oamNextAttr = 1'b0;
    bus.oamNextEntry = 1'b0;
    if (en) begin
      d = (d == 340) ? 0 : d + 1;
      n_evr += int'(bus.spriteEvalReset);
      n_eval += int'(bus.spriteEval_EN);
      n_fetch += int'(bus.spriteFetch_EN);
      n_shift += int'(bus.pixelShifty_EN);
      n_rflag += int'(bus.resetFlags);
      if (bus.spriteFetch_EN && bus.primaryAddress != 8'h00) n_fnz++;
      if (bus.cpuComm_EN) begin
        n_comm++;
        if (comm_q.size() == 0) begin
          check("comm_unexpected", 1, 0);
        end else begin
          e = comm_q.pop_front();
          check("comm_rw", 32'(bus.cpuRW), 32'(e.rw));
          check("comm_addr", 32'(bus.primaryAddress), 32'(e.addr));
        end
      end
    end
    while (addr_q.size() > 0)
      check("addr", 32'(bus.primaryAddress), 32'(addr_q.pop_front()));
  endtask

  task automatic cpu(input logic rd, input logic [2:0] sel,
                     input logic [7:0] data);
    bus.regSel = sel;
    bus.cpuData_IN = data;
    bus.regRead = rd;
    bus.regWrite = ~rd;
    tick();
  endtask

  task automatic finish_line();
    for (int i = 0; i < 400 && d != 0; i++) tick();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 400 && d != target; i++) tick();
  endtask

  task automatic run_line(input int line);
    bus.scanline = 9'(line);
    d = 0;
    snap();
    tick();
    finish_line();
  endtask

  initial begin
    reset = 1'b1;
    bus.clock_EN = 1'b1;
    bus.dot = '0;
    bus.scanline = '0;
    bus.showSprites = 1'b0;
    bus.showBackground = 1'b0;
    bus.regSel = '0;
    bus.regWrite = 1'b0;
    bus.regRead = 1'b0;
    bus.cpuData_IN = '0;
    bus.oamNextAttr = 1'b0;
    bus.oamNextEntry = 1'b0;
    tick();
    tick();
    check("rst_outs", 32'({bus.spriteEvalReset, bus.spriteEval_EN,
          bus.spriteFetch_EN, bus.pixelShifty_EN, bus.resetFlags,
          bus.cpuComm_EN, bus.cpuRW}), 0);
    check("rst_addr", 32'(bus.primaryAddress), 0);
    reset = 1'b0;

    bus.showSprites = 1'b1;
    run_line(10);
    check("l10_evr", n_evr - s_evr, 1);
    check("l10_eval", n_eval - s_eval, 256);
    check("l10_shift", n_shift - s_shift, 256);
    check("l10_fetch", n_fetch - s_fetch, 64);
    check("l10_fetch_addr", n_fnz - s_fnz, 0);

    run_line(261);
    check("pre_evr", n_evr - s_evr, 1);
    check("pre_rflag", n_rflag - s_rflag, 1);
    check("pre_eval", n_eval - s_eval, 0);
    check("pre_shift", n_shift - s_shift, 0);
    check("pre_fetch", n_fetch - s_fetch, 64);

    bus.showSprites = 1'b0;
    run_line(10);
    check("off_evr", n_evr - s_evr, 0);
    check("off_eval", n_eval - s_eval, 0);
    check("off_fetch", n_fetch - s_fetch, 0);
    run_line(261);
    check("off_pre_rflag", n_rflag - s_rflag, 1);
    check("off_pre_fetch", n_fetch - s_fetch, 0);

    bus.showBackground = 1'b1;
    bus.scanline = 9'd20;
    d = 0;
    run_to(100);
    bus.clock_EN = 1'b0;
    cpu(1'b0, 3'd3, 8'h10);
    bus.clock_EN = 1'b1;
    addr_q.push_back(8'h10); tick();
    for (int i = 1; i <= 3; i++) begin
      bus.oamNextAttr = 1'b1;
      addr_q.push_back(8'(8'h10 + i));
      tick();
    end
    bus.oamNextEntry = 1'b1;
    addr_q.push_back(8'h14); tick();
    bus.oamNextEntry = 1'b1;
    bus.oamNextAttr = 1'b1;
    addr_q.push_back(8'h18); tick();
    addr_q.push_back(8'h18);
    cpu(1'b0, 3'd3, 8'hFC);
    addr_q.push_back(8'hFC); tick();
    bus.oamNextEntry = 1'b1;
    addr_q.push_back(8'h00); tick();
    finish_line();

    bus.scanline = 9'd5;
    d = 0;
    snap();
    run_to(100);
    cpu(1'b0, 3'd3, 8'h21);
    addr_q.push_back(8'h21); tick();
    addr_q.push_back(8'h21);
    cpu(1'b0, 3'd4, 8'h55);
    addr_q.push_back(8'h25); tick();
    check("l5_no_comm", n_comm - s_comm, 0);
    addr_q.push_back(8'h25);
    cpu(1'b0, 3'd3, 8'h40);
    bus.oamNextAttr = 1'b1;
    addr_q.push_back(8'h40); tick();
    cpu(1'b1, 3'd4, 8'h00);
    comm_q.push_back('{1'b1, 8'h40});
    addr_q.push_back(8'h40); tick();
    finish_line();

    bus.showSprites = 1'b0;
    bus.showBackground = 1'b0;
    bus.scanline = 9'd240;
    snap();
    cpu(1'b0, 3'd3, 8'hFE);
    addr_q.push_back(8'hFE); tick();
    comm_q.push_back('{1'b0, 8'hFE});
    cpu(1'b0, 3'd4, 8'hAA);
    addr_q.push_back(8'hFE); tick();
    addr_q.push_back(8'hFF); tick();
    comm_q.push_back('{1'b0, 8'hFF});
    cpu(1'b0, 3'd4, 8'hBB);
    tick();
    addr_q.push_back(8'h00); tick();
    check("off_comm_count", n_comm - s_comm, 2);
    check("comm_left", comm_q.size(), 0);

    bus.showSprites = 1'b1;
    bus.scanline = 9'd50;
    d = 0;
    run_to(10);
    cpu(1'b0, 3'd3, 8'h33);
    run_to(100);
    check("l50_eval_on", 32'(bus.spriteEval_EN), 1);
    check("l50_addr", 32'(bus.primaryAddress), 32'h33);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_outs", 32'({bus.spriteEvalReset, bus.spriteEval_EN,
          bus.spriteFetch_EN, bus.pixelShifty_EN, bus.resetFlags,
          bus.cpuComm_EN, bus.cpuRW}), 0);
    check("mid_rst_addr", 32'(bus.primaryAddress), 0);
    tick();
    tick();
    reset = 1'b0;
    snap();
    finish_line();
    check("rel_eval", n_eval - s_eval, 0);
    check("rel_shift", n_shift - s_shift, 0);
    check("rel_fetch", n_fetch - s_fetch, 0);
    run_line(51);
    check("l51_eval", n_eval - s_eval, 256);
    check("l51_fetch", n_fetch - s_fetch, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
